weight_buffer_ctrl: RTL and testbench

//  Sequences the weight buffer through one filter pass per output channel:

---
 rtl/weight_buffer_ctrl.sv | 148 ++++++++++++++
 tb/tb_weight_buffer_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_ctrl.sv
// Weight buffer sequencer: runs one load/wait/stream/compute/free pass per filter,
// generates the weight memory byte address and watches for stalled loads.
module weight_buffer_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned MODE_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_start,
    input  logic [MODE_W-1:0] mode_in,
    input  logic [CNT_W-1:0]  num_filters,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pe_ready,
    input  logic              pe_compute_done,
    input  logic              wb_mem_req,
    input  logic              mem_data_valid,
    input  logic              wb_ready,
    input  logic              wb_finish,
    output logic [MODE_W-1:0] wb_mode,
    output logic              wb_start_load,
    output logic              wb_output_filter,
    output logic              wb_free,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CNT_W-1:0]  filter_idx,
    output logic              busy,
    output logic              layer_done,
    output logic              load_timeout
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [MODE_W-1:0] MODE1 = '0;

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_PE, STREAM, COMPUTE, FREE, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  nf_q, nf_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              to_q, to_d;
    logic              start_load_q, start_load_d;
    logic              out_filter_q, out_filter_d;
    logic              free_q, free_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              zero_done;

    always_comb begin
        state_d   = state_q;
        nf_d      = nf_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        wd_d      = '0;
        to_d      = to_q;
        zero_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (layer_start) begin
                    to_d = 1'b0;
                    if (num_filters != '0) begin
                        nf_d    = num_filters;
                        mode_d  = mode_in;
                        addr_d  = base_addr;
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (wb_mem_req && mem_data_valid) addr_d = addr_q + ADDR_W'(8);
                // watchdog saturates at TIMEOUT so the flag is raised exactly once per pass
                wd_d = (wd_q != WD_W'(TIMEOUT)) ? wd_q + WD_W'(1) : wd_q;
                if (wd_q == WD_W'(TIMEOUT - 1)) to_d = 1'b1;
                if (wb_ready) state_d = WAIT_PE;
            end
            WAIT_PE: if (pe_ready)        state_d = STREAM;
            STREAM:  if (wb_finish)       state_d = COMPUTE;
            COMPUTE: if (pe_compute_done) state_d = FREE;
            FREE: begin
                if (idx_q == nf_q - CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // outputs are decoded from the next state so they line up with state_q
        start_load_d = (state_d == LOAD) || (state_d == WAIT_PE) ||
                       (state_d == STREAM) || (state_d == COMPUTE);
        out_filter_d = (state_d == STREAM);
        free_d       = (state_d == FREE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE) || zero_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            nf_q         <= '0;
            mode_q       <= MODE1;
            addr_q       <= '0;
            idx_q        <= '0;
            wd_q         <= '0;
            to_q         <= 1'b0;
            start_load_q <= 1'b0;
            out_filter_q <= 1'b0;
            free_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            nf_q         <= nf_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            wd_q         <= wd_d;
            to_q         <= to_d;
            start_load_q <= start_load_d;
            out_filter_q <= out_filter_d;
            free_q       <= free_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign wb_mode          = mode_q;
    assign wb_start_load    = start_load_q;
    assign wb_output_filter = out_filter_q;
    assign wb_free          = free_q;
    assign mem_addr         = addr_q;
    assign filter_idx       = idx_q;
    assign busy             = busy_q;
    assign layer_done       = done_q;
    assign load_timeout     = to_q;

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Self-checking bench for weight_buffer_ctrl: table-driven layers, hand-written
// corner sequences and randomized layers checked against arithmetic expectations.
module tb_weight_buffer_ctrl;

    localparam int unsigned TO = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        layer_start;
    logic [1:0]  mode_in;
    logic [7:0]  num_filters;
    logic [31:0] base_addr;
    logic        pe_ready, pe_compute_done, wb_mem_req, mem_data_valid, wb_ready, wb_finish;
    logic [1:0]  wb_mode;
    logic        wb_start_load, wb_output_filter, wb_free, busy, layer_done, load_timeout;
    logic [31:0] mem_addr;
    logic [7:0]  filter_idx;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned free_cnt = 0;
    int unsigned done_cnt = 0;

    weight_buffer_ctrl #(.ADDR_W(32), .CNT_W(8), .TIMEOUT(TO), .MODE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .layer_start(layer_start), .mode_in(mode_in),
        .num_filters(num_filters), .base_addr(base_addr), .pe_ready(pe_ready),
        .pe_compute_done(pe_compute_done), .wb_mem_req(wb_mem_req),
        .mem_data_valid(mem_data_valid), .wb_ready(wb_ready), .wb_finish(wb_finish),
        .wb_mode(wb_mode), .wb_start_load(wb_start_load), .wb_output_filter(wb_output_filter),
        .wb_free(wb_free), .mem_addr(mem_addr), .filter_idx(filter_idx), .busy(busy),
        .layer_done(layer_done), .load_timeout(load_timeout)
    );

    always #5 clk = ~clk;

    // pulse counters: sampled at the rising edge, before outputs update
    always @(posedge clk) begin
        if (wb_free)    free_cnt <= free_cnt + 1;
        if (layer_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no_finish want finish");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        int unsigned nf;
        logic [31:0] base;
        int unsigned beats;
        int unsigned pdly;
        bit          stray;
        logic [31:0] exp_fin;
    } vec_t;

    task automatic run_layer(input logic [1:0] m, input int unsigned nf, input logic [31:0] base,
                             input int unsigned beats, input int unsigned pdly, input bit stray,
                             input logic [31:0] exp_fin);
        int unsigned free0, done0;
        free0 = free_cnt;
        done0 = done_cnt;
        layer_start = 1'b1; mode_in = m; num_filters = 8'(nf); base_addr = base;
        tick();
        layer_start = 1'b0;
        base_addr   = $urandom;
        chk("start_busy", 32'(busy), 1);
        chk("start_addr", mem_addr, base);
        chk("start_mode", 32'(wb_mode), 32'(m));
        chk("start_to_clear", 32'(load_timeout), 0);
        for (int unsigned k = 0; k < nf; k++) begin
            chk("load_idx", 32'(filter_idx), k);
            chk("load_sl", 32'(wb_start_load), 1);
            chk("load_free", 32'(wb_free), 0);
            if (stray) begin
                layer_start = 1'b1; num_filters = 8'd7; mode_in = m + 2'd1;
                pe_compute_done = 1'b1; pe_ready = 1'b1; wb_finish = 1'b1;
                tick();
                layer_start = 1'b0; num_filters = 8'(nf); mode_in = m;
                pe_compute_done = 1'b0; pe_ready = 1'b0; wb_finish = 1'b0;
                chk("stray_idx", 32'(filter_idx), k);
                chk("stray_mode", 32'(wb_mode), 32'(m));
                chk("stray_of", 32'(wb_output_filter), 0);
                chk("stray_free", 32'(wb_free), 0);
            end
            for (int unsigned b = 0; b < beats; b++) begin
                if ($urandom_range(0, 2) == 0) begin
                    wb_mem_req = $urandom_range(0, 1) == 1;
                    mem_data_valid = !wb_mem_req;
                    tick();
                end
                wb_mem_req = 1'b1; mem_data_valid = 1'b1;
                tick();
            end
            wb_mem_req = 1'b0; mem_data_valid = 1'b0;
            wb_ready = 1'b1; pe_ready = (pdly == 0);
            tick();
            wb_ready = 1'b0;
            chk("wait_sl", 32'(wb_start_load), 1);
            chk("wait_of", 32'(wb_output_filter), 0);
            for (int unsigned d = 0; d < pdly; d++) begin
                tick();
                chk("wait_hold_of", 32'(wb_output_filter), 0);
            end
            pe_ready = 1'b1;
            tick();
            pe_ready = 1'b0;
            chk("stream_of", 32'(wb_output_filter), 1);
            chk("stream_sl", 32'(wb_start_load), 1);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("stream_hold_of", 32'(wb_output_filter), 1);
            end
            wb_finish = 1'b1;
            tick();
            wb_finish = 1'b0;
            chk("comp_of", 32'(wb_output_filter), 0);
            chk("comp_sl", 32'(wb_start_load), 1);
            repeat ($urandom_range(0, 3)) tick();
            chk("comp_free", 32'(wb_free), 0);
            pe_compute_done = 1'b1;
            tick();
            pe_compute_done = 1'b0;
            chk("free_pulse", 32'(wb_free), 1);
            chk("free_sl", 32'(wb_start_load), 0);
            chk("free_busy", 32'(busy), 1);
            tick();
        end
        chk("done_pulse", 32'(layer_done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_free", 32'(wb_free), 0);
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(layer_done), 0);
        chk("idle_sl", 32'(wb_start_load), 0);
        chk("final_addr", mem_addr, exp_fin);
        chk("free_count", free_cnt - free0, nf);
        chk("done_count", done_cnt - done0, 1);
    endtask

    vec_t vecs[5];

    initial begin
        int unsigned done0;
        vecs[0] = '{2'd0, 1, 32'h0000_1000, 88, 0, 1'b0, 32'h0000_12C0};
        vecs[1] = '{2'd2, 3, 32'h0000_2000, 4,  5, 1'b0, 32'h0000_2060};
        vecs[2] = '{2'd1, 1, 32'hFFFF_FFF0, 4,  1, 1'b0, 32'h0000_0010};
        vecs[3] = '{2'd2, 2, 32'h0000_0040, 2,  2, 1'b1, 32'h0000_0060};
        vecs[4] = '{2'd1, 2, 32'h0000_0300, 0,  0, 1'b0, 32'h0000_0300};

        rst_n = 1'b0; layer_start = 1'b0; mode_in = 2'd3; num_filters = '0; base_addr = '0;
        pe_ready = 1'b0; pe_compute_done = 1'b0; wb_mem_req = 1'b0; mem_data_valid = 1'b0;
        wb_ready = 1'b0; wb_finish = 1'b0;
        tick(); tick();
        chk("rst_flags", 32'({wb_start_load, wb_output_filter, wb_free, busy, layer_done, load_timeout}), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_idx", 32'(filter_idx), 0);
        chk("rst_mode", 32'(wb_mode), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++)
            run_layer(vecs[i].mode, vecs[i].nf, vecs[i].base, vecs[i].beats,
                      vecs[i].pdly, vecs[i].stray, vecs[i].exp_fin);

        // zero filters: done pulse without ever going busy
        done0 = done_cnt;
        layer_start = 1'b1; num_filters = 8'd0; base_addr = 32'h9000;
        tick();
        layer_start = 1'b0;
        chk("zero_done", 32'(layer_done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_sl", 32'(wb_start_load), 0);
        tick();
        chk("zero_done_clear", 32'(layer_done), 0);
        chk("zero_busy2", 32'(busy), 0);
        chk("zero_done_count", done_cnt - done0, 1);

        // load watchdog: flag after TO load cycles, state held, sticky past the layer
        layer_start = 1'b1; mode_in = 2'd0; num_filters = 8'd1; base_addr = 32'h0;
        tick();
        layer_start = 1'b0;
        repeat (TO - 1) tick();
        chk("to_before", 32'(load_timeout), 0);
        tick();
        chk("to_set", 32'(load_timeout), 1);
        chk("to_sl_held", 32'(wb_start_load), 1);
        repeat (3) tick();
        chk("to_sticky_load", 32'(load_timeout), 1);
        chk("to_still_load", 32'({busy, wb_start_load, wb_output_filter}), 32'b110);
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        pe_ready = 1'b1; tick(); pe_ready = 1'b0;
        wb_finish = 1'b1; tick(); wb_finish = 1'b0;
        pe_compute_done = 1'b1; tick(); pe_compute_done = 1'b0;
        tick(); tick();
        chk("to_idle_busy", 32'(busy), 0);
        chk("to_sticky_idle", 32'(load_timeout), 1);
        run_layer(2'd0, 1, 32'h800, 1, 0, 1'b0, 32'h808);

        // async reset in STREAM, then a clean restart
        done0 = done_cnt;
        layer_start = 1'b1; mode_in = 2'd2; num_filters = 8'd2; base_addr = 32'h500;
        tick();
        layer_start = 1'b0;
        wb_mem_req = 1'b1; mem_data_valid = 1'b1;
        repeat (3) tick();
        wb_mem_req = 1'b0; mem_data_valid = 1'b0;
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        pe_ready = 1'b1; tick(); pe_ready = 1'b0;
        chk("rst_pre_of", 32'(wb_output_filter), 1);
        chk("rst_pre_addr", mem_addr, 32'h518);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flags", 32'({wb_start_load, wb_output_filter, wb_free, busy, layer_done, load_timeout}), 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_idx_mode", 32'({filter_idx, wb_mode}), 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("arst_no_done", done_cnt - done0, 0);
        chk("arst_idle", 32'(busy), 0);
        run_layer(2'd1, 2, 32'h700, 3, 1, 1'b0, 32'h730);

        for (int r = 0; r < 6; r++) begin
            logic [1:0]  m;
            int unsigned nf, beats;
            logic [31:0] base;
            m     = 2'($urandom_range(0, 2));
            nf    = $urandom_range(1, 4);
            beats = $urandom_range(0, 6);
            base  = $urandom & 32'hFFFF_FFF8;
            run_layer(m, nf, base, beats, $urandom_range(0, 4), $urandom_range(0, 1) == 1,
                      base + 32'(nf * beats * 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
